instruction_fetch: RTL

Fetch stage of the MIPS pipeline. It owns the program counter, drives the word address into the asynchronous-read instruction memory, and registers the returned word into the IF/ID pipeline register for decode. It supports hazard stalls and branch/jump redirects from downstream, and can optionally stop fetching at the test-done instruction.

---
 rtl/instruction_fetch.sv | 79 +++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, instruction-memory address, and the IF/ID pipeline register.
// Optional stop-at-test-done behaviour is enabled by defining FETCH_HALT_EN.
module instruction_fetch #(
   parameter int unsigned      AW       = 6,
   parameter int unsigned      DW       = 32,
   parameter logic [AW-1:0]    RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   output logic [AW-1:0] imem_a,
   input  logic [DW-1:0] imem_rd,
   output logic [DW-1:0] if_instr,
   output logic [AW-1:0] if_pc,
   output logic [AW-1:0] if_pc_next,
   output logic          if_valid,
   output logic          halted
);

   logic [AW-1:0] pc;
   logic          run_c;

`ifdef FETCH_HALT_EN
   localparam logic [0:0]    RUN       = 1'b0;
   localparam logic [0:0]    HALT      = 1'b1;
   localparam logic [DW-1:0] DONE_WORD = DW'(32'h1000_0000);

   logic [0:0] state;
   logic [0:0] state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   // Halt only when the test-done word is actually delivered downstream.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (!redirect_valid && !stall && imem_rd == DONE_WORD) state_nxt = HALT;
         HALT:    state_nxt = HALT;
         default: state_nxt = RUN;
      endcase
   end

   assign run_c  = (state == RUN);
   assign halted = (state == HALT);
`else
   assign run_c  = 1'b1;
   assign halted = 1'b0;
`endif

   // PC and IF/ID register; redirect beats stall, halt freezes everything but if_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         if_instr <= '0;
         if_pc    <= '0;
         if_valid <= 1'b0;
      end else if (!run_c) begin
         if_valid <= 1'b0;
      end else if (redirect_valid) begin
         pc       <= redirect_pc;
         if_instr <= '0;
         if_valid <= 1'b0;
      end else if (!stall) begin
         pc       <= pc + AW'(1);
         if_instr <= imem_rd;
         if_pc    <= pc;
         if_valid <= 1'b1;
      end
   end

   assign imem_a     = pc;
   assign if_pc_next = if_pc + AW'(1);

endmodule
